// File: rtl/mult_if.sv
// Decoder-to-multiplier handshake and HI/LO result bus.
// master: control side (issues start_mult, reads HI/LO); slave: mult_unit.
interface mult_if #(
    parameter int WIDTH = 32
);
    logic             start_mult;
    logic             mult_sign;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start_mult, mult_sign, op_a, op_b,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start_mult, mult_sign, op_a, op_b,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_unit.sv
// Multi-cycle shift-add HI/LO multiplier for MULT / MULTU.
// Signed multiplies run on operand magnitudes; the sign is applied once at
// completion by negating the 2*WIDTH accumulator.
// Optional build macro MULT_RADIX4_EN: retire two multiplier bits per cycle
// (0/1x/2x/3x multiplicand, 3x precomputed at capture), halving RUN length.
//
// state | meaning
// IDLE  | waiting for start_mult; HI/LO hold last product
// RUN   | one step per cycle; HI/LO written on the last step
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  reset_n,
    mult_if.slave bus
);
    localparam int PW = 2 * WIDTH;
`ifdef MULT_RADIX4_EN
    localparam int STEPS = WIDTH / 2;
`else
    localparam int STEPS = WIDTH;
`endif
    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic             neg_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
`ifdef MULT_RADIX4_EN
    logic [PW-1:0]    mcand3_q;
    logic [PW-1:0]    mcand3_init;
`endif

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    prod_d;

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as an unsigned value.
    always_comb begin
        mag_a = bus.op_a;
        mag_b = bus.op_b;
        if (bus.mult_sign && bus.op_a[WIDTH-1]) mag_a = -bus.op_a;
        if (bus.mult_sign && bus.op_b[WIDTH-1]) mag_b = -bus.op_b;
    end

`ifdef MULT_RADIX4_EN
    // 3x multiplicand, built from the magnitude being captured.
    always_comb begin
        mcand3_init = ({{WIDTH{1'b0}}, mag_a} << 1) + {{WIDTH{1'b0}}, mag_a};
    end
`endif

    // Partial product for the current step, running sum and signed final product.
    always_comb begin
`ifdef MULT_RADIX4_EN
        case (mplier_q[1:0])
            2'b00:   pp = '0;
            2'b01:   pp = mcand_q;
            2'b10:   pp = mcand_q << 1;
            default: pp = mcand3_q;
        endcase
`else
        pp = mplier_q[0] ? mcand_q : '0;
`endif
        acc_d  = acc_q + pp;
        prod_d = neg_q ? (~acc_d + PW'(1)) : acc_d;
    end

    // Control FSM, datapath registers and registered HI/LO/busy/done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MULT_RADIX4_EN
            mcand3_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_mult) begin
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        neg_q    <= bus.mult_sign & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
`ifdef MULT_RADIX4_EN
                        mcand3_q <= mcand3_init;
`endif
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
`ifdef MULT_RADIX4_EN
                    mcand_q  <= mcand_q << 2;
                    mcand3_q <= mcand3_q << 2;
                    mplier_q <= mplier_q >> 2;
`else
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
`endif
                    if (cnt_q == LAST) begin
                        hi_q    <= prod_d[PW-1:WIDTH];
                        lo_q    <= prod_d[WIDTH-1:0];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit (WIDTH = 32), scoreboard of expected products.
module tb_mult_unit;
    localparam int WIDTH = 32;
    localparam int PW    = 64;
`ifdef MULT_RADIX4_EN
    localparam int RUN_CYC = WIDTH / 2;
`else
    localparam int RUN_CYC = WIDTH;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    mult_if #(.WIDTH(WIDTH)) bus ();
    mult_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [PW-1:0] sb_q[$];

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    // Reference product: extend to 2*WIDTH and multiply modulo 2^(2*WIDTH).
    function automatic logic [PW-1:0] model(input bit s, input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
        logic [PW-1:0] ea, eb;
        ea = s ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb = s ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ea * eb;
    endfunction

    task automatic issue(input bit s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [PW-1:0] exp);
        @(posedge clk);
        #1;
        bus.start_mult = 1'b1;
        bus.mult_sign  = s;
        bus.op_a       = a;
        bus.op_b       = b;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start_mult = 1'b0;
    endtask

    // Waits (bounded) for done; reports busy cycles, cycles waited, and whether HI/LO held.
    task automatic wait_done(output int busy_cyc, output int waited, output bit held,
                             output logic [PW-1:0] prev, output bit timeout);
        bit first;
        first = 1'b1;
        busy_cyc = 0;
        waited = 0;
        held = 1'b1;
        timeout = 1'b1;
        prev = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (first) begin
                prev = {bus.hi, bus.lo};
                first = 1'b0;
            end
            if (bus.done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (bus.busy === 1'b1) busy_cyc++;
            if ({bus.hi, bus.lo} !== prev) held = 1'b0;
            waited++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start_mult = 1'b1;
        bus.mult_sign = 1'b0;
        bus.op_a = 32'd5;
        bus.op_b = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        bus.start_mult = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_with_start busy: got %b expected 0", bus.busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.hi !== '0) begin errors++; $display("FAIL reset hi: got %h expected 0", bus.hi); end
        checks++;
        if (bus.lo !== '0) begin errors++; $display("FAIL reset lo: got %h expected 0", bus.lo); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL reset done: got %b (pulses %0d) expected 0", bus.done, done_cnt);
        end
    endtask

    task automatic test_multu_max();
        int bc, w;
        bit held, to;
        logic [PW-1:0] prev, exp;
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        wait_done(bc, w, held, prev, to);
        exp = sb_q.pop_front();
        checks++;
        if (to) begin errors++; $display("FAIL multu_max timeout: no done within 200 cycles"); end
        checks++;
        if ({bus.hi, bus.lo} !== exp) begin
            errors++;
            $display("FAIL multu_max product: got %h expected %h", {bus.hi, bus.lo}, exp);
        end
        checks++;
        if (bc != RUN_CYC) begin errors++; $display("FAIL multu_max busy_cycles: got %0d expected %0d", bc, RUN_CYC); end
        checks++;
        if (w != RUN_CYC) begin errors++; $display("FAIL multu_max latency: got %0d expected %0d", w, RUN_CYC); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL multu_max busy_at_done: got %b expected 0", bus.busy); end
        checks++;
        if (!held || prev !== '0) begin errors++; $display("FAIL multu_max hold: got %h held=%0d expected 0", prev, held); end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_max done_width: got %b expected 0", bus.done); end
    endtask

    task automatic test_signed();
        logic [WIDTH-1:0] ta[8];
        logic [WIDTH-1:0] tb[8];
        bit               ts[8];
        logic [PW-1:0]    te[8];
        int bc, w;
        bit held, to;
        logic [PW-1:0] prev, exp;
        ta[0] = -32'sd3;       tb[0] = 32'd5;         ts[0] = 1; te[0] = 64'hFFFF_FFFF_FFFF_FFF1;
        ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF; ts[1] = 1; te[1] = 64'h0000_0000_0000_0001;
        ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000; ts[2] = 1; te[2] = 64'h4000_0000_0000_0000;
        ta[3] = 32'h8000_0000; tb[3] = 32'd1;         ts[3] = 1; te[3] = 64'hFFFF_FFFF_8000_0000;
        for (int i = 4; i < 8; i++) begin
            ta[i] = $urandom;
            tb[i] = $urandom;
            ts[i] = i[0];
            te[i] = model(ts[i], ta[i], tb[i]);
        end
        for (int i = 0; i < 8; i++) begin
            issue(ts[i], ta[i], tb[i], te[i]);
            wait_done(bc, w, held, prev, to);
            exp = sb_q.pop_front();
            checks++;
            if (to || {bus.hi, bus.lo} !== exp) begin
                errors++;
                $display("FAIL signed[%0d] %h*%h s=%0d: got %h expected %h timeout=%0d",
                         i, ta[i], tb[i], ts[i], {bus.hi, bus.lo}, exp, to);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [PW-1:0] prev, exp;
        int base, w;
        bit held, seen;
        issue(1'b0, 32'd7, 32'd6, 64'd42);
        base = done_cnt;
        held = 1'b1;
        seen = 1'b0;
        w = 0;
        @(negedge clk);
        prev = {bus.hi, bus.lo};
        for (int i = 1; i < 200; i++) begin
            if (bus.done === 1'b1) begin seen = 1'b1; break; end
            if ({bus.hi, bus.lo} !== prev) held = 1'b0;
            w++;
            if (i == 10) begin
                bus.start_mult = 1'b1;
                bus.op_a = 32'd2;
                bus.op_b = 32'd2;
            end else begin
                bus.start_mult = 1'b0;
            end
            @(negedge clk);
        end
        bus.start_mult = 1'b0;
        exp = sb_q.pop_front();
        checks++;
        if (!seen || {bus.hi, bus.lo} !== exp) begin
            errors++;
            $display("FAIL busy_ignore product: got %h expected %h seen=%0d", {bus.hi, bus.lo}, exp, seen);
        end
        checks++;
        if (w != RUN_CYC) begin errors++; $display("FAIL busy_ignore latency: got %0d expected %0d", w, RUN_CYC); end
        checks++;
        if (!held) begin errors++; $display("FAIL busy_ignore hold: HI/LO changed before done, prev %h", prev); end
        repeat (RUN_CYC + 5) @(negedge clk);
        #1;
        checks++;
        if (done_cnt - base != 1) begin errors++; $display("FAIL busy_ignore done_count: got %0d expected 1", done_cnt - base); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_ignore busy_after: got %b expected 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int bc, w;
        bit held, to;
        logic [PW-1:0] prev, exp;
        issue(1'b0, 32'd3, 32'd4, 64'd12);
        wait_done(bc, w, held, prev, to);
        exp = sb_q.pop_front();
        checks++;
        if (to || {bus.hi, bus.lo} !== exp) begin
            errors++;
            $display("FAIL b2b first: got %h expected %h", {bus.hi, bus.lo}, exp);
        end
        bus.start_mult = 1'b1;
        bus.mult_sign = 1'b0;
        bus.op_a = 32'd5;
        bus.op_b = 32'd5;
        sb_q.push_back(64'd25);
        @(posedge clk);
        #1;
        bus.start_mult = 1'b0;
        wait_done(bc, w, held, prev, to);
        exp = sb_q.pop_front();
        checks++;
        if (to || {bus.hi, bus.lo} !== exp) begin
            errors++;
            $display("FAIL b2b second: got %h expected %h", {bus.hi, bus.lo}, exp);
        end
        checks++;
        if (!held || prev !== 64'd12) begin
            errors++;
            $display("FAIL b2b hold: got %h held=%0d expected 0c", prev, held);
        end
        checks++;
        if (w != RUN_CYC) begin errors++; $display("FAIL b2b latency: got %0d expected %0d", w, RUN_CYC); end
    endtask

    task automatic test_reset_mid();
        int base, bc, w;
        bit held, to;
        logic [PW-1:0] prev, exp;
        issue(1'b1, -32'sd7, 32'd9, model(1'b1, -32'sd7, 32'd9));
        base = done_cnt;
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        void'(sb_q.pop_back());
        checks++;
        if ({bus.hi, bus.lo} !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid state: got hi/lo %h busy %b done %b expected 0",
                     {bus.hi, bus.lo}, bus.busy, bus.done);
        end
        repeat (RUN_CYC + 10) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != base) begin errors++; $display("FAIL reset_mid stray_done: got %0d expected 0", done_cnt - base); end
        issue(1'b0, 32'd123, 32'd456, model(1'b0, 32'd123, 32'd456));
        wait_done(bc, w, held, prev, to);
        exp = sb_q.pop_front();
        checks++;
        if (to || {bus.hi, bus.lo} !== exp) begin
            errors++;
            $display("FAIL reset_mid restart: got %h expected %h", {bus.hi, bus.lo}, exp);
        end
    endtask

    initial begin
        bus.start_mult = 1'b0;
        bus.mult_sign = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        test_reset();
        test_multu_max();
        test_signed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d expected 0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
